// File: rtl/apu_pkg.sv
// Shared types and constants for the APU pulse channel register front end.
// The sweep adjuster arithmetic lives here so that the top and the sweep unit agree on it.
package apu_pkg;

   typedef logic [1:0]  duty_t;
   typedef logic [10:0] period_t;
   typedef logic [1:0]  reg_addr_t;

   typedef struct packed {
      logic       enable;
      logic [2:0] period;
      logic       negate;
      logic [2:0] shift;
   } sweep_reg_t;

   localparam reg_addr_t APU_REG_CTRL  = 2'd0;
   localparam reg_addr_t APU_REG_SWEEP = 2'd1;
   localparam reg_addr_t APU_REG_LO    = 2'd2;
   localparam reg_addr_t APU_REG_HI    = 2'd3;

   // 12-bit sweep target; bit 11 flags an overflow past the 11-bit period range.
   function automatic logic [11:0] sweep_target(input period_t p, input logic [2:0] s,
                                                input logic neg);
      logic [11:0] cur;
      logic [11:0] change;
      cur    = {1'b0, p};
      change = cur >> s;
      if (neg) begin
         return cur - change;
      end else begin
         return cur + change;
      end
   endfunction

endpackage

// File: rtl/apu_sweep.sv
// Sweep unit: sweep register, half-frame divider with reload, mute test and update strobe.
// Only instantiated when APU_PULSE_SWEEP_EN is defined.
module apu_sweep
   import apu_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       half_frame,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   input  period_t    period,
   input  logic       period_pending,
   output logic       upd,
   output period_t    target
);

   sweep_reg_t  sweep_r;
   logic [2:0]  divider_r;
   logic        reload_r;
   logic [11:0] target_s;
   logic        mute_s;

   assign target_s = sweep_target(period, sweep_r.shift, sweep_r.negate);
   assign mute_s   = (period < 11'd8) || target_s[11];
   assign target   = target_s[10:0];

   // A pending period message blocks the update outright; it is not retried later.
   assign upd = half_frame && (divider_r == 3'd0) && sweep_r.enable &&
                (sweep_r.shift != 3'd0) && !mute_s && !period_pending;

   // Sweep register capture from CPU writes to address 1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sweep_r <= sweep_reg_t'(8'd0);
      end else if (wr_en) begin
         sweep_r <= sweep_reg_t'(wr_data);
      end
   end

   // Divider countdown on half-frame ticks; a sweep write arms a reload.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         divider_r <= 3'd0;
         reload_r  <= 1'b0;
      end else begin
         if (half_frame) begin
            if ((divider_r == 3'd0) || reload_r) begin
               divider_r <= sweep_r.period;
               reload_r  <= 1'b0;
            end else begin
               divider_r <= divider_r - 3'd1;
            end
         end
         if (wr_en) begin
            reload_r <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/apu_pulse_regs.sv
// Pulse channel register front end: CPU byte writes in, duty and period messages out.
// Optional feature macro: APU_PULSE_SWEEP_EN (adds apu__half_frame and the sweep unit).
module apu_pulse_regs
   import apu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
`ifdef APU_PULSE_SWEEP_EN
   input  logic        apu__half_frame,
`endif
   input  logic [9:0]  apu__reg_r,
   input  logic        apu__reg_r_vld,
   output logic        apu__reg_r_rdy,
   output logic [1:0]  apu__duty_s,
   output logic        apu__duty_s_vld,
   input  logic        apu__duty_s_rdy,
   output logic [10:0] apu__period_s,
   output logic        apu__period_s_vld,
   input  logic        apu__period_s_rdy
);

   reg_addr_t  addr_s;
   logic [7:0] data_s;
   logic       reg_rdy_s;
   logic       wr_fire_s;
   logic       duty_wr_s;
   logic       period_wr_s;
   logic       sweep_wr_s;
   period_t    period_next_s;
   logic       sweep_upd_s;
   period_t    sweep_target_s;

   logic       duty_pending_r;
   duty_t      duty_stage_r;
   logic       period_pending_r;
   period_t    period_r;
   period_t    period_stage_r;

   assign addr_s      = apu__reg_r[9:8];
   assign data_s      = apu__reg_r[7:0];
   assign wr_fire_s   = apu__reg_r_vld && reg_rdy_s;
   assign duty_wr_s   = wr_fire_s && (addr_s == APU_REG_CTRL);
   assign sweep_wr_s  = wr_fire_s && (addr_s == APU_REG_SWEEP);
   assign period_wr_s = wr_fire_s && ((addr_s == APU_REG_LO) || (addr_s == APU_REG_HI));

   // Ready depends only on registered pending state and the offered address.
   always_comb begin
      case (addr_s)
         APU_REG_CTRL:  reg_rdy_s = !duty_pending_r;
         APU_REG_SWEEP: reg_rdy_s = 1'b1;
         APU_REG_LO:    reg_rdy_s = !period_pending_r;
         APU_REG_HI:    reg_rdy_s = !period_pending_r;
         default:       reg_rdy_s = 1'b1;
      endcase
   end

   // Merge the written byte into the 11-bit period shadow.
   always_comb begin
      if (addr_s == APU_REG_LO) begin
         period_next_s = {period_r[10:8], data_s};
      end else if (addr_s == APU_REG_HI) begin
         period_next_s = {data_s[2:0], period_r[7:0]};
      end else begin
         period_next_s = period_r;
      end
   end

`ifdef APU_PULSE_SWEEP_EN
   apu_sweep u_sweep (
      .clk            (clk),
      .reset          (reset),
      .half_frame     (apu__half_frame),
      .wr_en          (sweep_wr_s),
      .wr_data        (data_s),
      .period         (period_r),
      .period_pending (period_pending_r),
      .upd            (sweep_upd_s),
      .target         (sweep_target_s)
   );
`else
   // Without the sweep unit, address 1 writes are accepted and dropped.
   logic unused_sweep_wr_s;
   assign unused_sweep_wr_s = sweep_wr_s;
   assign sweep_upd_s       = 1'b0;
   assign sweep_target_s    = 11'd0;
`endif

   // Duty channel: staging register plus pending flag cleared by the downstream handshake.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         duty_pending_r <= 1'b0;
         duty_stage_r   <= 2'd0;
      end else if (duty_wr_s) begin
         duty_pending_r <= 1'b1;
         duty_stage_r   <= data_s[7:6];
      end else if (duty_pending_r && apu__duty_s_rdy) begin
         duty_pending_r <= 1'b0;
      end
   end

   // Period channel: a CPU write outranks a same-cycle sweep update, which is then dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         period_pending_r <= 1'b0;
         period_r         <= 11'd0;
         period_stage_r   <= 11'd0;
      end else if (period_wr_s) begin
         period_pending_r <= 1'b1;
         period_r         <= period_next_s;
         period_stage_r   <= period_next_s;
      end else if (sweep_upd_s) begin
         period_pending_r <= 1'b1;
         period_r         <= sweep_target_s;
         period_stage_r   <= sweep_target_s;
      end else if (period_pending_r && apu__period_s_rdy) begin
         period_pending_r <= 1'b0;
      end
   end

   assign apu__reg_r_rdy    = reg_rdy_s;
   assign apu__duty_s       = duty_stage_r;
   assign apu__duty_s_vld   = duty_pending_r;
   assign apu__period_s     = period_stage_r;
   assign apu__period_s_vld = period_pending_r;

endmodule

// File: tb/tb_apu_pulse_regs.sv
// Scoreboard bench for apu_pulse_regs: randomized writes and backpressure against a
// behavioural register/sweep model; a negedge monitor compares every presented message.
module tb_apu_pulse_regs;

`ifdef APU_PULSE_SWEEP_EN
   localparam bit SWEEP = 1'b1;
   logic half_frame;
`else
   localparam bit SWEEP = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic [9:0]  reg_w;
   logic        reg_vld;
   logic        reg_rdy;
   logic [1:0]  duty_s;
   logic        duty_vld;
   logic        duty_rdy;
   logic [10:0] period_s;
   logic        period_vld;
   logic        period_rdy;

   apu_pulse_regs dut (
      .clk               (clk),
      .reset             (reset),
`ifdef APU_PULSE_SWEEP_EN
      .apu__half_frame   (half_frame),
`endif
      .apu__reg_r        (reg_w),
      .apu__reg_r_vld    (reg_vld),
      .apu__reg_r_rdy    (reg_rdy),
      .apu__duty_s       (duty_s),
      .apu__duty_s_vld   (duty_vld),
      .apu__duty_s_rdy   (duty_rdy),
      .apu__period_s     (period_s),
      .apu__period_s_vld (period_vld),
      .apu__period_s_rdy (period_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // scoreboard queues of expected messages
   int dq[$];
   int pq[$];

   // behavioural model state
   bit m_duty_busy, m_per_busy, m_reload;
   int m_period, m_div, m_sweep;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      dq.delete();
      pq.delete();
      m_duty_busy = 0; m_per_busy = 0; m_reload = 0;
      m_period = 0; m_div = 0; m_sweep = 0;
   endtask

   // monitor: output valid must match scoreboard occupancy, data must match its head
   always @(negedge clk) begin
      if (!reset) begin
         chk("duty_vld", {31'd0, duty_vld}, {31'd0, dq.size() != 0});
         if (duty_vld && dq.size() != 0) begin
            chk("duty_data", {30'd0, duty_s}, dq[0]);
            if (duty_rdy) void'(dq.pop_front());
         end
         chk("period_vld", {31'd0, period_vld}, {31'd0, pq.size() != 0});
         if (period_vld && pq.size() != 0) begin
            chk("period_data", {21'd0, period_s}, pq[0]);
            if (period_rdy) void'(pq.pop_front());
         end
      end
   end

   // one clock cycle of stimulus; model advances at the active edge
   task automatic cyc(input bit wv, input int a, input int d, input bit dr, input bit pr,
                      input bit hf, output bit acc);
      bit exp_rdy, busy_old, tick, upd;
      int en, per, neg, sh, change, tgt;
      #1;
      reg_w = {a[1:0], d[7:0]};
      reg_vld = wv; duty_rdy = dr; period_rdy = pr;
`ifdef APU_PULSE_SWEEP_EN
      half_frame = hf;
`endif
      #1;
      exp_rdy = (a == 0) ? !m_duty_busy : (a == 1) ? 1'b1 : !m_per_busy;
      chk("reg_rdy", {31'd0, reg_rdy}, {31'd0, exp_rdy});
      @(posedge clk);
      acc = wv && exp_rdy;
      busy_old = m_per_busy;
      if (m_duty_busy && dr) m_duty_busy = 0;
      if (m_per_busy && pr) m_per_busy = 0;
      tick = hf && SWEEP;
      upd = 0;
      if (tick) begin
         en = (m_sweep >> 7) & 1; per = (m_sweep >> 4) & 7;
         neg = (m_sweep >> 3) & 1; sh = m_sweep & 7;
         change = m_period >> sh;
         tgt = neg ? m_period - change : m_period + change;
         upd = (m_div == 0) && en && (sh != 0) && !(m_period < 8 || tgt > 2047) && !busy_old;
         if (m_div == 0 || m_reload) begin
            m_div = per; m_reload = 0;
         end else begin
            m_div = m_div - 1;
         end
      end
      if (acc) begin
         case (a)
            0: begin dq.push_back((d >> 6) & 3); m_duty_busy = 1; end
            1: begin if (SWEEP) begin m_sweep = d & 255; m_reload = 1; end end
            2: begin m_period = (m_period & 'h700) | (d & 255); upd = 0;
                     pq.push_back(m_period); m_per_busy = 1; end
            default: begin m_period = (m_period & 'hFF) | ((d & 7) << 8); upd = 0;
                     pq.push_back(m_period); m_per_busy = 1; end
         endcase
      end
      if (upd) begin
         m_period = tgt;
         pq.push_back(m_period);
         m_per_busy = 1;
      end
   endtask

   task automatic wr(input int a, input int d);
      bit acc;
      for (int i = 0; i < 4; i++) begin
         cyc(1, a, d, 1, 1, 0, acc);
         if (acc) break;
      end
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 1, 0, acc);
   endtask

   initial begin
      bit acc;
      reset = 1'b1; reg_vld = 1'b0; reg_w = 10'd0; duty_rdy = 1'b0; period_rdy = 1'b0;
`ifdef APU_PULSE_SWEEP_EN
      half_frame = 1'b0;
`endif
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_duty_vld", {31'd0, duty_vld}, 32'd0);
      chk("rst_period_vld", {31'd0, period_vld}, 32'd0);
      chk("rst_rdy", {31'd0, reg_rdy}, 32'd1);
      chk("rst_period_s", {21'd0, period_s}, 32'd0);
      reset = 1'b0;
      idle(3);

      // duty under backpressure: held stable, further duty writes stalled
      cyc(1, 0, 'hC0, 0, 1, 0, acc);
      for (int i = 0; i < 5; i++) begin
         cyc(1, 0, 'h40, 0, 1, 0, acc);
         #1 chk("duty_hold", {30'd0, duty_s}, 32'd3);
      end
      cyc(0, 0, 0, 1, 1, 0, acc);
      #1 chk("duty_drop", {31'd0, duty_vld}, 32'd0);

      // split period write with stall; duty write passes during the stall
      cyc(1, 2, 'h34, 1, 0, 0, acc);
      #1 chk("period_lo", {21'd0, period_s}, 32'h034);
      cyc(1, 3, 'h05, 1, 0, 0, acc);
      cyc(1, 0, 'h80, 1, 0, 0, acc);
      cyc(1, 3, 'h05, 1, 1, 0, acc);
      cyc(1, 3, 'h05, 1, 0, 0, acc);
      #1 chk("period_hi", {21'd0, period_s}, 32'h534);
      idle(2);

      // sweep register write: no message on either channel
      wr(1, 'hFF);
      idle(3);
      wr(1, 'h00);
      idle(2);

`ifdef APU_PULSE_SWEEP_EN
      wr(2, 'h00); wr(3, 'h01); wr(1, 'h81); idle(2);
      cyc(0, 0, 0, 1, 0, 1, acc);
      #1 chk("sweep_add", {21'd0, period_s}, 32'h180);
      idle(2);
      wr(2, 'h00); wr(3, 'h01); wr(1, 'h89); idle(2);
      cyc(0, 0, 0, 1, 0, 1, acc);
      #1 chk("sweep_neg", {21'd0, period_s}, 32'h080);
      idle(2);
      wr(2, 'hF0); wr(3, 'h07); wr(1, 'h81); idle(2);
      cyc(0, 0, 0, 1, 1, 1, acc);
      #1 chk("sweep_mute", {31'd0, period_vld}, 32'd0);
      idle(2);
`endif

      // randomized traffic with random backpressure and ticks
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom % 3) != 0, $urandom_range(0, 3), $urandom_range(0, 255),
             ($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 6) == 0, acc);
      end
      idle(4);
      chk("drain_duty", dq.size(), 32'd0);
      chk("drain_period", pq.size(), 32'd0);

      // reset while a period message is waiting
      cyc(1, 2, 'hAA, 1, 0, 0, acc);
      #1 chk("pre_rst_vld", {31'd0, period_vld}, 32'd1);
      reset = 1'b1;
      #1;
      chk("async_period_vld", {31'd0, period_vld}, 32'd0);
      chk("async_duty_vld", {31'd0, duty_vld}, 32'd0);
      model_clear();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("post_rst_period_s", {21'd0, period_s}, 32'd0);
      idle(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
